sync_pulse_arbiter: RTL

// Shares one fast-to-slow pulse sync channel among NUM_REQ requesters, all in
// one clock domain. Each requester's high pulses are counted. The block then

---
 rtl/sync_pulse_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sync_pulse_arbiter.sv
// Round-robin arbiter that queues pulse events from several requesters and
// issues them one at a time onto a single shared fast-to-slow sync channel.
module sync_pulse_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = 4,
  parameter int GAP_CYCLES  = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_pulse,
  input  logic                       ch_ack,
  input  logic                       clr_err,
  output logic                       ch_pulse,
  output logic [$clog2(NUM_REQ)-1:0] ch_id,
  output logic                       busy,
  output logic                       pending_any,
  output logic [NUM_REQ-1:0]         overflow,
  output logic                       timeout_err
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  // With no gap configured, an ack (or timeout) returns straight to IDLE.
  localparam state_t ACK_EXIT = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg  [NUM_REQ];
  logic [CNT_W-1:0]   cnt_next [NUM_REQ];
  logic [NUM_REQ-1:0] nz_vec;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] overflow_set;
  logic [NUM_REQ-1:0] overflow_reg, overflow_next;
  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]    ch_id_reg, ch_id_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic               ch_pulse_reg, ch_pulse_next;
  logic               timeout_err_reg, timeout_err_next;
  logic               timeout_set;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    scan_idx;
  int                 scan_sum;

  // Per-requester pending counters; a simultaneous request and grant cancel out.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic inc, dec, sat;

      assign inc = req_pulse[gi];
      assign dec = grant_vec[gi];
      assign sat = (cnt_reg[gi] == CNT_MAX);

      assign nz_vec[gi]       = (cnt_reg[gi] != '0);
      assign grant_vec[gi]    = (state_reg == ISSUE) && (ch_id_reg == ID_W'(gi));
      assign overflow_set[gi] = inc && !dec && sat;
      assign cnt_next[gi]     = (inc && !dec && !sat) ? cnt_reg[gi] + 1'b1 :
                                (dec && !inc)         ? cnt_reg[gi] - 1'b1 :
                                                        cnt_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  // Scan from the highest offset down so the lowest offset past rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_sum   = 0;
    scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = int'(rr_ptr_reg) + k;
      if (scan_sum >= NUM_REQ) begin
        scan_sum = scan_sum - NUM_REQ;
      end
      scan_idx = ID_W'(scan_sum);
      if (nz_vec[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    ch_id_next  = ch_id_reg;
    timer_next  = timer_reg;
    timeout_set = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          ch_id_next = pick_idx;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_next = (ch_id_reg == ID_LAST) ? '0 : ch_id_reg + ID_W'(1);
        timer_next  = '0;
        state_next  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ch_ack) begin
          timer_next = '0;
          state_next = ACK_EXIT;
        end else if (timer_reg == ACK_LAST) begin
          // The lost event is dropped rather than reissued.
          timeout_set = 1'b1;
          timer_next  = '0;
          state_next  = ACK_EXIT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      GAP: begin
        if (timer_reg == GAP_LAST) begin
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Error flags are sticky; a new error in the clearing cycle survives.
  assign ch_pulse_next    = (state_next == ISSUE);
  assign timeout_err_next = timeout_set | (timeout_err_reg & ~clr_err);
  assign overflow_next    = overflow_set | (overflow_reg & ~{NUM_REQ{clr_err}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      ch_id_reg       <= '0;
      timer_reg       <= '0;
      ch_pulse_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      overflow_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      ch_id_reg       <= ch_id_next;
      timer_reg       <= timer_next;
      ch_pulse_reg    <= ch_pulse_next;
      timeout_err_reg <= timeout_err_next;
      overflow_reg    <= overflow_next;
    end
  end

  assign ch_pulse    = ch_pulse_reg;
  assign ch_id       = ch_id_reg;
  assign busy        = (state_reg != IDLE);
  assign pending_any = |nz_vec;
  assign overflow    = overflow_reg;
  assign timeout_err = timeout_err_reg;

endmodule
